// File: rtl/shift_pkg.sv
// Shared definitions for the two-stage barrel shifter: op encodings and the coarse/fine rank split.
// SHIFT_PIPE_SRL_EN enables logical right shift on op 2'b10; otherwise that op is a pass.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SRL  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

    // Number of most-significant shift ranks applied in stage 1; the rest go to stage 2.
    localparam int N_COARSE_RANKS = 2;

    function automatic logic op_is_pass(input logic [1:0] op);
`ifdef SHIFT_PIPE_SRL_EN
        return op == OP_PASS;
`else
        return (op == OP_PASS) || (op == OP_SRL);
`endif
    endfunction

    function automatic logic op_is_right(input logic [1:0] op);
`ifdef SHIFT_PIPE_SRL_EN
        return (op == OP_SRA) || (op == OP_SRL);
`else
        return op == OP_SRA;
`endif
    endfunction

endpackage

// File: rtl/shift_rank.sv
// Single shift rank: moves data by a fixed AMT positions when enabled.
// dir_i = 0 shifts left with zero fill, dir_i = 1 shifts right with fill_i.
module shift_rank #(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            if (dir_i) begin
                data_o = {{AMT{fill_i}}, data_i[WIDTH-1:AMT]};
            end else begin
                data_o = {data_i[WIDTH-AMT-1:0], {AMT{1'b0}}};
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter with valid/ready on both sides (coarse ranks in S1, fine in S2).
// SHIFT_PIPE_SRL_EN selects logical right shift for op 2'b10; undefined, op 2'b10 is a pass.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    // Handshake: a transfer happens on a rising edge where valid && ready; a producer holds
    // its payload while valid is high and ready is low. in_ready never depends on in_valid.

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int N_FINE  = SHAMT_W - N_COARSE_RANKS;

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_data_q, s1_data_d;
    logic [N_FINE-1:0]    s1_shamt_q, s1_shamt_d;
    logic [1:0]           s1_op_q, s1_op_d;
    logic                 s1_fill_q, s1_fill_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     s2_data_q, s2_data_d;
    logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;

    logic s1_load, s2_load;
    logic in_pass, in_right, in_fill;

    logic [N_COARSE_RANKS:0][WIDTH-1:0] coarse;
    logic [N_FINE:0][WIDTH-1:0]         fine;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !reset;

    assign in_pass  = op_is_pass(in_op);
    assign in_right = op_is_right(in_op);
    assign in_fill  = (in_op == OP_SRA) && in_data[WIDTH-1];

    assign coarse[0] = in_data;

    genvar g;
    for (g = 0; g < N_COARSE_RANKS; g++) begin : g_coarse
        shift_rank #(
            .WIDTH(WIDTH),
            .AMT  (WIDTH >> (g + 1))
        ) u_rank (
            .data_i(coarse[g]),
            .en_i  (in_shamt[SHAMT_W-1-g] && !in_pass),
            .dir_i (in_right),
            .fill_i(in_fill),
            .data_o(coarse[g+1])
        );
    end

    // A pass op stores a zero fine amount, so stage 2 needs no separate pass decode.
    assign fine[0] = s1_data_q;

    for (g = 0; g < N_FINE; g++) begin : g_fine
        shift_rank #(
            .WIDTH(WIDTH),
            .AMT  (1 << g)
        ) u_rank (
            .data_i(fine[g]),
            .en_i  (s1_shamt_q[g]),
            .dir_i (op_is_right(s1_op_q)),
            .fill_i(s1_fill_q),
            .data_o(fine[g+1])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        s1_op_d    = s1_op_q;
        s1_fill_d  = s1_fill_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            s1_data_d  = coarse[N_COARSE_RANKS];
            s1_shamt_d = in_pass ? '0 : in_shamt[N_FINE-1:0];
            s1_op_d    = in_op;
            s1_fill_d  = in_fill;
            s1_tag_d   = in_tag;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = fine[N_FINE];
            s2_tag_d   = s1_tag_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shamt_q <= '0;
            s1_op_q    <= 2'b00;
            s1_fill_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shamt_q <= s1_shamt_d;
            s1_op_q    <= s1_op_d;
            s1_fill_q  <= s1_fill_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_valid_q ? s2_data_q : '0;
    assign out_tag   = s2_valid_q ? s2_tag_q : '0;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases plus random traffic against a reference model.
// Honours SHIFT_PIPE_SRL_EN the same way as the design.
module tb_shift_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int SW    = 5;

`ifdef SHIFT_PIPE_SRL_EN
    localparam logic [WIDTH-1:0] EXP_OP10 = 32'h0800_0000;
`else
    localparam logic [WIDTH-1:0] EXP_OP10 = 32'h8000_0000;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [SW-1:0]     in_shamt;
    logic [1:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic [TAG_W+WIDTH-1:0] exp_q[$];

    shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_op    (in_op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    // clock / reset
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [SW-1:0] sa,
                                               input logic [1:0] op);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        case (op)
            2'b00: return d << sa;
            2'b01: return sd >>> sa;
`ifdef SHIFT_PIPE_SRL_EN
            2'b10: return d >> sa;
`else
            2'b10: return d;
`endif
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // One clock cycle: drive at negedge, then settle and run the scoreboard for the coming edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic [SW-1:0] sa,
                         input logic [1:0] op, input logic [TAG_W-1:0] tg, input logic ordy,
                         output logic acc);
        logic [TAG_W+WIDTH-1:0] e;
        @(negedge clock);
        in_valid  = iv;
        in_data   = d;
        in_shamt  = sa;
        in_op     = op;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (!reset) begin
            if (!out_valid) check("idle_zero", 64'({out_tag, out_data}), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'({out_tag, out_data}), 64'(e));
                    n_pops++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({tg, model(d, sa, op)});
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        logic a;
        cycle(1'b0, '0, '0, 2'b00, '0, ordy, a);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            idle(1'b1);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic acc, acc2;
        int p0, k, sent;
        logic [WIDTH-1:0] bp_d[3];
        logic [SW-1:0]    bp_s[3];
        logic [1:0]       bp_o[3];
        logic             pend;
        logic [WIDTH-1:0] r_d;
        logic [SW-1:0]    r_s;
        logic [1:0]       r_o;
        logic [TAG_W-1:0] r_t;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1 check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_out_data", 64'(out_data), 64'd0);
        check("post_rst_out_tag", 64'(out_tag), 64'd0);

        // SRA latency and sign fill
        cycle(1'b1, 32'h8000_0000, 5'd16, 2'b01, 5'd3, 1'b1, acc);
        check("sra_acc", 64'(acc), 64'd1);
        idle(1'b1);
        check("lat_first_cycle", 64'(out_valid), 64'd0);
        idle(1'b1);
        check("lat_valid", 64'(out_valid), 64'd1);
        check("sra16_data", 64'(out_data), 64'hFFFF_8000);
        check("sra16_tag", 64'(out_tag), 64'd3);
        drain(10);

        // back-to-back, consecutive outputs
        p0 = n_pops;
        cycle(1'b1, 32'h0000_0001, 5'd31, 2'b00, 5'd1, 1'b1, acc);
        cycle(1'b1, 32'hDEAD_BEEF, 5'd0, 2'b00, 5'd2, 1'b1, acc2);
        check("b2b_accepts", 64'({acc, acc2}), 64'd3);
        idle(1'b1);
        check("b2b_first", 64'(n_pops - p0), 64'd1);
        idle(1'b1);
        check("b2b_second", 64'(n_pops - p0), 64'd2);
        drain(10);

        // backpressure: out_ready low for 4 cycles while 3 ops are offered
        bp_d[0] = 32'h1234_5678; bp_s[0] = 5'd4; bp_o[0] = 2'b00;
        bp_d[1] = 32'hF000_000F; bp_s[1] = 5'd3; bp_o[1] = 2'b01;
        bp_d[2] = 32'hCAFE_F00D; bp_s[2] = 5'd9; bp_o[2] = 2'b11;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            if (k < 3) cycle(1'b1, bp_d[k], bp_s[k], bp_o[k], 5'(7 + k), 1'b0, acc);
            else       cycle(1'b0, '0, '0, 2'b00, '0, 1'b0, acc);
            if (acc) k++;
            if (c >= 2) check("bp_hold_data", 64'({out_valid, out_data}),
                              64'({1'b1, model(bp_d[0], bp_s[0], bp_o[0])}));
        end
        check("bp_accepts", 64'(k), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        p0 = n_pops;
        for (int c = 0; c < 10; c++) begin
            if (k < 3) cycle(1'b1, bp_d[k], bp_s[k], bp_o[k], 5'(7 + k), 1'b1, acc);
            else       cycle(1'b0, '0, '0, 2'b00, '0, 1'b1, acc);
            if (acc) k++;
        end
        check("bp_all_out", 64'(n_pops - p0), 64'd3);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset with two ops in flight
        cycle(1'b1, 32'h0000_00FF, 5'd2, 2'b00, 5'd11, 1'b0, acc);
        cycle(1'b1, 32'h0000_0F0F, 5'd1, 2'b00, 5'd12, 1'b0, acc2);
        check("mid_accepts", 64'({acc, acc2}), 64'd3);
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b1;
        #1 check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
        repeat (6) idle(1'b1);

        // op 10 behaviour depends on configuration
        cycle(1'b1, 32'h8000_0000, 5'd4, 2'b10, 5'd5, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);
        check("op10_result", 64'(out_data), 64'(EXP_OP10));
        drain(10);

        // random traffic
        pend = 1'b0; sent = 0;
        r_d = '0; r_s = '0; r_o = '0; r_t = '0;
        for (int i = 0; i < 60000 && sent < 10000; i++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                r_d  = $urandom;
                case ($urandom_range(0, 5))
                    0:       r_s = 5'd0;
                    1:       r_s = 5'd31;
                    default: r_s = 5'($urandom_range(0, 31));
                endcase
                r_o = 2'($urandom_range(0, 3));
                r_t = 5'($urandom_range(0, 31));
            end
            cycle(pend, r_d, r_s, r_o, r_t, $urandom_range(0, 9) < 7, acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
        end
        check("rand_sent", 64'(sent), 64'd10000);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Two-stage pipelined 32-bit barrel shifter with a valid/ready handshake on both sides. It sits between operand select/bypass in the execute stage and the writeback mux, and performs SLL/SRA (optionally SRL) for shift-class instructions. It uses single-rank shift primitives: stage 1 applies the coarse ranks (16, 8) and stage 2 the fine ranks (4, 2, 1). Full throughput is one operation per cycle, with stall propagation under backpressure.

## Interface
- WIDTH, 32, data width; power of two ≥ 8; SHAMT_W = log2(WIDTH) is derived, not overridable
- TAG_W, 5, width of sideband tag (destination register id) carried alongside the data
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  in  1  operation presented
- in_ready  out  1  shifter can accept this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount, unsigned
- in_op  in  2  00 SLL, 01 SRA, 10 SRL/pass (see Configuration), 11 pass
- in_tag  in  TAG_W  sideband, returned unmodified
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of this result

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage registers: S1 holds {valid, partial data, shamt[SHAMT_W-3:0], op, tag}. S2 holds {valid, result, tag}. out_* are driven directly from S2.
- S1 datapath: ranks of WIDTH/2 and WIDTH/4, enabled by shamt[SHAMT_W-1] and shamt[SHAMT_W-2] respectively.
- S2 datapath: remaining ranks, enabled by the low shamt bits.
- Shift semantics:
  - SLL fills with zeros.
  - SRA fills with the original in_data[WIDTH-1]. The sign bit is captured into S1 and used for the fine ranks.
  - SRL fills with zeros.
  - Pass returns in_data unchanged; in_shamt is ignored.
- in_shamt = 0 returns in_data for every op.
- There is no error or exception output.
- Stall logic:
  - S2 loads when !S2.valid || out_ready.
  - S1 loads when !S1.valid || S2 loads.
  - in_ready = S1 load condition, with no combinational path from in_valid.
- Each register holds its contents when not loading. Data and tag are stable while out_valid && !out_ready.
- Ordering is strict FIFO. No operation is dropped or duplicated.
- When a stage's valid clears, its data may stay stale, but out_data and out_tag must read 0 when out_valid = 0.

## Timing
- Latency: accepted at edge N, out_valid at edge N+2 when there is no backpressure.
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure:
  - out_ready low with S2 full stalls S2.
  - S1 fills on the following cycle, then in_ready drops.
  - Capacity is 2 in-flight ops.
- Simultaneous events: an output transfer and an S1→S2 advance in the same cycle are both honoured, with no bubble.
- Reset:
  - During reset: in_ready = 0.
  - Cycle after reset deasserts: in_ready = 1, out_valid = 0, out_data = 0, out_tag = 0.
  - Both valid bits clear, and in-flight ops are discarded without output.
- Reset asserted mid-operation wins over any load in the same cycle.

## Configuration
- SHIFT_PIPE_SRL_EN defined: op 10 = logical right shift.
- SHIFT_PIPE_SRL_EN undefined: op 10 behaves as pass, identical to op 11. No SRL fill logic is synthesised.

## Structure
- shift_pkg: op encodings (OP_SLL, OP_SRA, OP_SRL, OP_PASS) and a localparam for the S1/S2 rank split.
- One sub-module, shift_rank: combinational, one instance per rank.
  - Parameters: WIDTH and AMT.
  - Inputs: data, en, dir, fill bit.
  - Output: data shifted by AMT when en is set, else unchanged.
- Instance count: 5 for WIDTH = 32.

## Test plan
- SRA 0x8000_0000, shamt 16, tag 3, out_ready high: 2 cycles later out_data = 0xFFFF_8000, out_tag = 3.
- SLL 0x0000_0001 shamt 31, then SLL 0xDEAD_BEEF shamt 0, back-to-back: 0x8000_0000 and 0xDEAD_BEEF on consecutive cycles, in order.
- out_ready low for 4 cycles while 3 ops are offered:
  - in_ready drops after 2 accepts.
  - out_data holds stable.
  - On release, all 3 results emerge in order, none lost.
- Reset asserted while 2 ops are in flight: out_valid = 0 the cycle after release, no stale result ever appears, in_ready = 1.
- Op 10, data 0x8000_0000, shamt 4: result 0x0800_0000 with SHIFT_PIPE_SRL_EN; 0x8000_0000 without.
- Random 10k ops with random in_valid/out_ready against a reference model: zero mismatches, order preserved.
